// File: rtl/m_pool_sched.sv
// Ping-pong bank scheduler between the layer-1 feature-map writer and the
// max-pool/ReLU reader; tracks bank occupancy, issues one pass per filled bank.
module m_pool_sched #(
    parameter int CH_NUM = 4,
    parameter int CH_W   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_done,
    output logic            wr_bank,
    output logic            wr_allow,
    output logic            pool_start,
    output logic            rd_bank,
    input  logic            pool_done,
    output logic [CH_W-1:0] ch_idx,
    output logic            busy,
    output logic            layer_done,
    input  logic            layer_clear,
    output logic            err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);
    localparam logic [CH_W-1:0] CH_MAX  = CH_W'(CH_NUM);

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      full;
    logic [1:0]      full_nxt;
    logic [CH_W-1:0] wr_cnt;
    logic            clr;
    logic            wr_acc;
    logic            wr_rej;
    logic            rd_fin;

    // Every output is decoded from registered state only.
    assign wr_allow   = !full[wr_bank] && (wr_cnt < CH_MAX);
    assign pool_start = (state == S_START);
    assign busy       = (state == S_START) || (state == S_RUN);
    assign layer_done = (state == S_DONE);

    assign clr    = (state == S_DONE) && layer_clear;
    // A write colliding with the layer rearm is refused so the new layer starts empty.
    assign wr_acc = wr_done && wr_allow && !clr;
    assign wr_rej = wr_done && !wr_acc;
    assign rd_fin = (state == S_RUN) && pool_done;

    always_comb begin
        full_nxt = full;
        if (rd_fin) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_acc) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (full[rd_bank]) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (pool_done) begin
                    state_nxt = (ch_idx == CH_LAST) ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (layer_clear) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            ch_idx  <= '0;
            wr_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            if (wr_rej) begin
                err <= 1'b1;
            end
            if (clr) begin
                full    <= 2'b00;
                wr_bank <= 1'b0;
                rd_bank <= 1'b0;
                ch_idx  <= '0;
                wr_cnt  <= '0;
            end else begin
                full <= full_nxt;
                if (wr_acc) begin
                    wr_bank <= !wr_bank;
                    wr_cnt  <= wr_cnt + 1'b1;
                end
                if (rd_fin) begin
                    rd_bank <= !rd_bank;
                    if (ch_idx != CH_LAST) begin
                        ch_idx <= ch_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_m_pool_sched.sv
// Directed bench for m_pool_sched: reset, single pass, ping-pong overlap,
// full layer with rearm, overflow and collision errors, asynchronous mid-pass reset.
module tb_m_pool_sched;

    localparam int CH_NUM = 4;
    localparam int CH_W   = 3;

    logic            clk;
    logic            rst;
    logic            wr_done;
    logic            wr_bank;
    logic            wr_allow;
    logic            pool_start;
    logic            rd_bank;
    logic            pool_done;
    logic [CH_W-1:0] ch_idx;
    logic            busy;
    logic            layer_done;
    logic            layer_clear;
    logic            err;

    int checks = 0;
    int errors = 0;

    m_pool_sched #(.CH_NUM(CH_NUM), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_done    (wr_done),
        .wr_bank    (wr_bank),
        .wr_allow   (wr_allow),
        .pool_start (pool_start),
        .rd_bank    (rd_bank),
        .pool_done  (pool_done),
        .ch_idx     (ch_idx),
        .busy       (busy),
        .layer_done (layer_done),
        .layer_clear(layer_clear),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_done = 1'b0; pool_done = 1'b0; layer_clear = 1'b0;
        repeat (2) step();
        chk("rst_wr_bank", 32'(wr_bank), 0);
        chk("rst_wr_allow", 32'(wr_allow), 1);
        chk("rst_pool_start", 32'(pool_start), 0);
        chk("rst_rd_bank", 32'(rd_bank), 0);
        chk("rst_ch_idx", 32'(ch_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_layer_done", 32'(layer_done), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_pool_start", 32'(pool_start), 0);
            chk("idle_busy", 32'(busy), 0);
        end

        // single channel on bank 0
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("single_wr_bank", 32'(wr_bank), 1);
        chk("single_no_start_n1", 32'(pool_start), 0);
        chk("single_wr_allow", 32'(wr_allow), 1);
        step();
        chk("single_start_n2", 32'(pool_start), 1);
        chk("single_rd_bank", 32'(rd_bank), 0);
        chk("single_busy_start", 32'(busy), 1);
        step();
        chk("single_start_once", 32'(pool_start), 0);
        chk("single_busy_run", 32'(busy), 1);
        layer_clear = 1'b1; step(); layer_clear = 1'b0;
        chk("clear_ignored_busy", 32'(busy), 1);
        chk("clear_ignored_done", 32'(layer_done), 0);
        repeat (5) step();
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("single_pd_rd_bank", 32'(rd_bank), 1);
        chk("single_pd_ch_idx", 32'(ch_idx), 1);
        chk("single_pd_busy", 32'(busy), 0);
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("pd_idle_rd_bank", 32'(rd_bank), 1);
        chk("pd_idle_ch_idx", 32'(ch_idx), 1);
        step();
        chk("pd_idle_no_start", 32'(pool_start), 0);

        // ping-pong overlap: bank 1 pooled while bank 0 fills
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("pp_wr_bank_a", 32'(wr_bank), 0);
        chk("pp_wr_allow_a", 32'(wr_allow), 1);
        step();
        chk("pp_start_a", 32'(pool_start), 1);
        chk("pp_rd_bank_a", 32'(rd_bank), 1);
        repeat (8) step();
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("pp_wr_bank_b", 32'(wr_bank), 1);
        chk("pp_wr_allow_b", 32'(wr_allow), 0);
        repeat (3) step();
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("pp_k1_wr_allow", 32'(wr_allow), 1);
        chk("pp_k1_rd_bank", 32'(rd_bank), 0);
        chk("pp_k1_ch_idx", 32'(ch_idx), 2);
        chk("pp_k1_no_start", 32'(pool_start), 0);
        step();
        chk("pp_k2_start", 32'(pool_start), 1);
        chk("pp_k2_rd_bank", 32'(rd_bank), 0);

        // fourth write saturates the write count
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("w4_wr_bank", 32'(wr_bank), 0);
        chk("w4_wr_allow", 32'(wr_allow), 0);
        repeat (2) step();
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("p3_ch_idx", 32'(ch_idx), 3);
        chk("p3_rd_bank", 32'(rd_bank), 1);
        chk("p3_wr_allow_sat", 32'(wr_allow), 0);
        step();
        chk("p3_start", 32'(pool_start), 1);
        repeat (3) step();
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("p4_layer_done", 32'(layer_done), 1);
        chk("p4_wr_allow", 32'(wr_allow), 0);
        chk("p4_busy", 32'(busy), 0);
        chk("p4_ch_idx", 32'(ch_idx), 3);
        chk("p4_rd_bank", 32'(rd_bank), 0);
        chk("p4_err", 32'(err), 0);
        repeat (2) step();
        chk("done_hold", 32'(layer_done), 1);
        chk("done_no_start", 32'(pool_start), 0);

        // rearm with a colliding write: write refused, err set
        layer_clear = 1'b1; wr_done = 1'b1; step(); layer_clear = 1'b0; wr_done = 1'b0;
        chk("clr_layer_done", 32'(layer_done), 0);
        chk("clr_ch_idx", 32'(ch_idx), 0);
        chk("clr_wr_allow", 32'(wr_allow), 1);
        chk("clr_wr_bank", 32'(wr_bank), 0);
        chk("clr_rd_bank", 32'(rd_bank), 0);
        chk("clr_err", 32'(err), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("clr_no_start", 32'(pool_start), 0);
        end

        rst = 1'b1; step();
        chk("rst2_err", 32'(err), 0);
        rst = 1'b0; step();

        // overflow with both banks full
        wr_done = 1'b1; step(); wr_done = 1'b0;
        step();
        chk("ov_start", 32'(pool_start), 1);
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("ov_wr_bank_full", 32'(wr_bank), 0);
        chk("ov_wr_allow_full", 32'(wr_allow), 0);
        chk("ov_err_before", 32'(err), 0);
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("ov_err", 32'(err), 1);
        chk("ov_wr_bank", 32'(wr_bank), 0);
        chk("ov_wr_allow", 32'(wr_allow), 0);
        step();
        chk("ov_err_sticky", 32'(err), 1);

        // same-cycle write and pool_done on the bank being freed
        wr_done = 1'b1; pool_done = 1'b1; step(); wr_done = 1'b0; pool_done = 1'b0;
        chk("col_rd_bank", 32'(rd_bank), 1);
        chk("col_ch_idx", 32'(ch_idx), 1);
        chk("col_wr_allow", 32'(wr_allow), 1);
        chk("col_wr_bank", 32'(wr_bank), 0);
        chk("col_err", 32'(err), 1);
        chk("col_no_start_m1", 32'(pool_start), 0);
        step();
        chk("col_start_m2", 32'(pool_start), 1);
        chk("col_start_rd_bank", 32'(rd_bank), 1);

        // reach RUN with ch_idx == 2, then reset asynchronously
        wr_done = 1'b1; step(); wr_done = 1'b0;
        chk("mp_wr_bank", 32'(wr_bank), 1);
        pool_done = 1'b1; step(); pool_done = 1'b0;
        chk("mp_ch_idx", 32'(ch_idx), 2);
        step();
        chk("mp_start", 32'(pool_start), 1);
        step();
        chk("mp_busy", 32'(busy), 1);
        chk("mp_ch_idx_run", 32'(ch_idx), 2);
        #2 rst = 1'b1;
        #1;
        chk("ar_ch_idx", 32'(ch_idx), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_rd_bank", 32'(rd_bank), 0);
        chk("ar_wr_bank", 32'(wr_bank), 0);
        chk("ar_wr_allow", 32'(wr_allow), 1);
        chk("ar_err", 32'(err), 0);
        chk("ar_layer_done", 32'(layer_done), 0);
        chk("ar_pool_start", 32'(pool_start), 0);
        #2 rst = 1'b0;
        repeat (2) step();
        chk("post_rst_no_start", 32'(pool_start), 0);
        chk("post_rst_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
